// File: rtl/program_loader.sv
// Framed byte-stream memory loader. It writes COUNT words starting at BASE_ADDR and checks
// an XOR checksum, then releases the CPU at the entry PC taken from the frame header.
module program_loader #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_req,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic [ADDR_W-1:0] start_pc,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned PART_W = 24;
  localparam int unsigned HDR_W  = 16;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [HDR_W-1:0]    count_q, count_d;
  logic [7:0]          pc_lo_q, pc_lo_d;
  logic [ADDR_W-1:0]   entry_q, entry_d;
  logic [PART_W-1:0]   part_q, part_d;
  logic [7:0]          csum_q, csum_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                in_ready_q, in_ready_d;
  logic                cpu_run_q, cpu_run_d;
  logic [ADDR_W-1:0]   start_pc_q, start_pc_d;
  logic                err_q, err_d;

  logic                fire;
  logic [HDR_W-1:0]    hdr_pc;
  logic [ADDR_W:0]     words_inc;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    pc_lo_d    = pc_lo_q;
    entry_d    = entry_q;
    part_d     = part_q;
    csum_d     = csum_q;
    words_d    = words_q;
    wren_d     = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    fire       = in_valid && in_ready_q;
    hdr_pc     = {in_data, pc_lo_q};
    words_inc  = words_q + (ADDR_W+1)'(1);

    unique case (state_q)
      ST_HDR: begin
        if (fire) begin
          csum_d = csum_q ^ in_data;
          idx_d  = idx_q + IDX_W'(1);
          unique case (idx_q)
            2'd0: count_d[7:0]  = in_data;
            2'd1: count_d[15:8] = in_data;
            2'd2: pc_lo_d       = in_data;
            default: begin
              entry_d = ADDR_W'(hdr_pc);
              if ((32'(count_q) > DEPTH) || ((hdr_pc >> ADDR_W) != HDR_W'(0))) begin
                state_d = ST_ERR;
              end else if (count_q == HDR_W'(0)) begin
                state_d = ST_CHK;
              end else begin
                state_d = ST_DATA;
              end
            end
          endcase
        end
      end

      ST_DATA: begin
        if (fire) begin
          csum_d = csum_q ^ in_data;
          idx_d  = idx_q + IDX_W'(1);
          unique case (idx_q)
            2'd0: part_d[7:0]   = in_data;
            2'd1: part_d[15:8]  = in_data;
            2'd2: part_d[23:16] = in_data;
            default: begin
              // Address truncation gives the required modulo-depth wrap.
              wren_d  = 1'b1;
              addr_d  = ADDR_W'(BASE_ADDR + 32'(words_q));
              wdata_d = DATA_W'({in_data, part_q});
              words_d = words_inc;
              if (32'(words_inc) == 32'(count_q)) begin
                state_d = ST_CHK;
              end
            end
          endcase
        end
      end

      ST_CHK: begin
        if (fire) begin
          state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
        end
      end

      ST_DONE, ST_ERR: begin
        if (load_req) begin
          state_d = ST_HDR;
          idx_d   = '0;
          csum_d  = '0;
          words_d = '0;
        end
      end

      default: state_d = ST_HDR;
    endcase

    in_ready_d = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_CHK);
    cpu_run_d  = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
    start_pc_d = (state_d == ST_DONE) ? entry_q : '0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HDR;
      idx_q      <= '0;
      count_q    <= '0;
      pc_lo_q    <= '0;
      entry_q    <= '0;
      part_q     <= '0;
      csum_q     <= '0;
      words_q    <= '0;
      wren_q     <= 1'b0;
      addr_q     <= ADDR_W'(BASE_ADDR);
      wdata_q    <= '0;
      in_ready_q <= 1'b0;
      cpu_run_q  <= 1'b0;
      start_pc_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      pc_lo_q    <= pc_lo_d;
      entry_q    <= entry_d;
      part_q     <= part_d;
      csum_q     <= csum_d;
      words_q    <= words_d;
      wren_q     <= wren_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      in_ready_q <= in_ready_d;
      cpu_run_q  <= cpu_run_d;
      start_pc_q <= start_pc_d;
      err_q      <= err_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_wren     = wren_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign cpu_run      = cpu_run_q;
  assign start_pc     = start_pc_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule
